// File: rtl/csr_unit_if.sv
// Execute-stage CSR bus: instruction operands and trap/mret controls in,
// read data, legality and redirect targets out.
interface csr_unit_if;
  logic        csr_en;
  logic [2:0]  csr_op;
  logic [11:0] csr_addr;
  logic [4:0]  rs1_idx;
  logic [31:0] rs1_data;
  logic [31:0] zimm;
  logic        instr_retire;
  logic        trap_req;
  logic [31:0] trap_cause;
  logic [31:0] trap_pc;
  logic        mret;
  logic [31:0] csr_rdata;
  logic        illegal_csr;
  logic [31:0] trap_target;
  logic [31:0] mret_target;

  modport master (
    output csr_en, csr_op, csr_addr, rs1_idx, rs1_data, zimm,
           instr_retire, trap_req, trap_cause, trap_pc, mret,
    input  csr_rdata, illegal_csr, trap_target, mret_target
  );

  modport slave (
    input  csr_en, csr_op, csr_addr, rs1_idx, rs1_data, zimm,
           instr_retire, trap_req, trap_cause, trap_pc, mret,
    output csr_rdata, illegal_csr, trap_target, mret_target
  );
endinterface

// File: rtl/csr_unit.sv
// Machine-mode CSR file for the RV32I pipeline: Zicsr read-modify-write,
// 64-bit cycle/instret counters, trap entry and mret state.
module csr_unit #(
  parameter logic [31:0] MTVEC_RESET = 32'h0000_0000,
  parameter logic [31:0] HART_ID     = 32'h0000_0000
) (
  input logic       clk,
  input logic       rst,
  csr_unit_if.slave bus
);
  localparam logic [11:0] A_MSTATUS   = 12'h300;
  localparam logic [11:0] A_MISA      = 12'h301;
  localparam logic [11:0] A_MTVEC     = 12'h305;
  localparam logic [11:0] A_MSCRATCH  = 12'h340;
  localparam logic [11:0] A_MEPC      = 12'h341;
  localparam logic [11:0] A_MCAUSE    = 12'h342;
  localparam logic [11:0] A_MCYCLE    = 12'hB00;
  localparam logic [11:0] A_MINSTRET  = 12'hB02;
  localparam logic [11:0] A_MCYCLEH   = 12'hB80;
  localparam logic [11:0] A_MINSTRETH = 12'hB82;
  localparam logic [11:0] A_CYCLE     = 12'hC00;
  localparam logic [11:0] A_INSTRET   = 12'hC02;
  localparam logic [11:0] A_CYCLEH    = 12'hC80;
  localparam logic [11:0] A_INSTRETH  = 12'hC82;
  localparam logic [11:0] A_MHARTID   = 12'hF14;

  logic        mie_r;
  logic        mpie_r;
  logic [29:0] mtvec_r;
  logic [29:0] mepc_r;
  logic [31:0] mscratch_r;
  logic [31:0] mcause_r;
  logic [63:0] mcycle_r;
  logic [63:0] minstret_r;

  logic [31:0] old_s;
  logic [31:0] src_s;
  logic [31:0] new_s;
  logic        mapped_s;
  logic        wr_intent_s;
  logic        illegal_s;
  logic        wr_s;
  logic        unused_s;

  // Read mux: current architectural value of the addressed CSR
  always_comb begin
    old_s    = 32'h0000_0000;
    mapped_s = 1'b1;
    case (bus.csr_addr)
      A_MSTATUS:              old_s = {19'h0, 2'b11, 3'h0, mpie_r, 3'h0, mie_r, 3'h0};
      A_MISA:                 old_s = 32'h4000_0100;
      A_MTVEC:                old_s = {mtvec_r, 2'b00};
      A_MSCRATCH:             old_s = mscratch_r;
      A_MEPC:                 old_s = {mepc_r, 2'b00};
      A_MCAUSE:               old_s = mcause_r;
      A_MCYCLE, A_CYCLE:      old_s = mcycle_r[31:0];
      A_MCYCLEH, A_CYCLEH:    old_s = mcycle_r[63:32];
      A_MINSTRET, A_INSTRET:  old_s = minstret_r[31:0];
      A_MINSTRETH, A_INSTRETH: old_s = minstret_r[63:32];
      A_MHARTID:              old_s = HART_ID;
      default: begin
        old_s    = 32'h0000_0000;
        mapped_s = 1'b0;
      end
    endcase
  end

  // Operation decode, new value and legality; traps and mret drop the CSR write
  always_comb begin
    src_s       = bus.csr_op[2] ? bus.zimm : bus.rs1_data;
    wr_intent_s = (bus.csr_op[1:0] == 2'b01) || (bus.rs1_idx != 5'd0);
    case (bus.csr_op[1:0])
      2'b01:   new_s = src_s;
      2'b10:   new_s = old_s | src_s;
      2'b11:   new_s = old_s & ~src_s;
      default: new_s = old_s;
    endcase
    illegal_s = bus.csr_en & ((bus.csr_op[1:0] == 2'b00) | ~mapped_s |
                              (wr_intent_s & (bus.csr_addr[11:10] == 2'b11)));
    wr_s = bus.csr_en & ~illegal_s & wr_intent_s & ~bus.trap_req & ~bus.mret;
  end

  assign bus.csr_rdata   = (bus.csr_en & ~illegal_s) ? old_s : 32'h0000_0000;
  assign bus.illegal_csr = illegal_s;
  assign bus.trap_target = {mtvec_r, 2'b00};
  assign bus.mret_target = {mepc_r, 2'b00};
  assign unused_s        = ^bus.trap_pc[1:0];

  // State update: counters always advance, a counter write replaces only its half
  always_ff @(posedge clk) begin
    if (rst) begin
      mie_r      <= 1'b0;
      mpie_r     <= 1'b0;
      mtvec_r    <= MTVEC_RESET[31:2];
      mepc_r     <= 30'h0;
      mscratch_r <= 32'h0000_0000;
      mcause_r   <= 32'h0000_0000;
      mcycle_r   <= 64'h0;
      minstret_r <= 64'h0;
    end else begin
      mcycle_r   <= mcycle_r + 64'd1;
      minstret_r <= minstret_r + {63'd0, bus.instr_retire};
      if (wr_s) begin
        case (bus.csr_addr)
          A_MSTATUS: begin
            mie_r  <= new_s[3];
            mpie_r <= new_s[7];
          end
          A_MTVEC:     mtvec_r    <= new_s[31:2];
          A_MSCRATCH:  mscratch_r <= new_s;
          A_MEPC:      mepc_r     <= new_s[31:2];
          A_MCAUSE:    mcause_r   <= new_s;
          A_MCYCLE:    mcycle_r   <= {mcycle_r[63:32], new_s};
          A_MCYCLEH:   mcycle_r   <= {new_s, mcycle_r[31:0]};
          A_MINSTRET:  minstret_r <= {minstret_r[63:32], new_s};
          A_MINSTRETH: minstret_r <= {new_s, minstret_r[31:0]};
          default: begin
          end
        endcase
      end
      if (bus.trap_req) begin
        mepc_r   <= bus.trap_pc[31:2];
        mcause_r <= bus.trap_cause;
        mpie_r   <= mie_r;
        mie_r    <= 1'b0;
      end else if (bus.mret) begin
        mie_r  <= mpie_r;
        mpie_r <= 1'b1;
      end
    end
  end
endmodule
